bist_march_ctrl: RTL and testbench

BIST_MARCH_CTRL -- requirements
Module: bist_march_ctrl

---
 rtl/bist_march_pkg.sv | 17 +
 rtl/march_addr_gen.sv | 24 ++
 rtl/bist_march_ctrl.sv | 157 +++++++++++++++
 tb/tb_bist_march_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/bist_march_pkg.sv
// Shared types and March C- element tables for the BIST controller.
package bist_march_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
  typedef enum logic [2:0] {M0, M1, M2, M3, M4, M5} elem_e;

  // Background patterns; the controller replicates bit 0 to the data width.
  localparam logic [7:0] BG0 = 8'h00;
  localparam logic [7:0] BG1 = 8'hFF;

  // Per-element tables, bit index = element number.
  localparam logic [5:0] ELEM_TWO_OPS = 6'b011110;  // M1..M4 are (read, write)
  localparam logic [5:0] ELEM_DOWN    = 6'b011000;  // M3, M4 descend
  localparam logic [5:0] ELEM_EXP_ONE = 6'b010100;  // M2, M4 expect BG1
  localparam logic [5:0] ELEM_WR_ONE  = 6'b001010;  // M1, M3 write BG1

endpackage

// File: rtl/march_addr_gen.sv
// Up/down address counter for March elements, with terminal-address flag.
module march_addr_gen #(
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          load_down,
  input  logic          step,
  input  logic          down,
  output logic [AW-1:0] addr,
  output logic          last
);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst)       addr <= '0;
    else if (load) addr <= load_down ? '1 : '0;
    else if (step) addr <= down ? addr - AW'(1) : addr + AW'(1);
  end

  assign last = down ? (addr == '0) : (&addr);

endmodule

// File: rtl/bist_march_ctrl.sv
// March C- memory BIST controller: one memory op per cycle, one-stage read compare.
// Define MARCH_DIAG_EN to capture the address and element of the first mismatch.
module bist_march_ctrl
  import bist_march_pkg::*;
#(
  parameter int AW = 6,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          fail,
  output logic          mem_cs,
  output logic          mem_rwbar,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [AW-1:0] fail_addr,
  output logic [2:0]    fail_elem
);

  localparam logic [DW-1:0] PAT0 = {DW{BG0[0]}};
  localparam logic [DW-1:0] PAT1 = {DW{BG1[0]}};

  state_e        state;
  elem_e         elem;
  elem_e         elem_next;
  logic          phase;
  logic          last;
  logic          accept, op_read, addr_end, mismatch;
  logic          addr_load, addr_load_down, addr_step;
  logic          cmp_valid;
  logic [DW-1:0] cmp_exp;

  assign accept   = ((state == IDLE) || (state == DONE)) && start;
  assign op_read  = (elem != M0) && !phase;
  assign addr_end = phase || !ELEM_TWO_OPS[elem];
  assign mismatch = cmp_valid && (mem_rdata != cmp_exp);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    addr_load      = 1'b0;
    addr_load_down = 1'b0;
    addr_step      = 1'b0;
    elem_next      = elem;
    if (accept) begin
      addr_load = 1'b1;
    end else if (state == RUN && addr_end) begin
      if (!last) begin
        addr_step = 1'b1;
      end else if (elem != M5) begin
        elem_next      = elem_e'(elem + 3'd1);
        addr_load      = 1'b1;
        addr_load_down = ELEM_DOWN[elem_next];
      end
    end
  end

  march_addr_gen #(.AW(AW)) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (addr_load),
    .load_down (addr_load_down),
    .step      (addr_step),
    .down      (ELEM_DOWN[elem]),
    .addr      (mem_addr),
    .last      (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      elem      <= M0;
      phase     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fail      <= 1'b0;
      mem_cs    <= 1'b0;
      mem_rwbar <= 1'b1;
      mem_wdata <= '0;
      cmp_valid <= 1'b0;
      cmp_exp   <= '0;
    end else begin
      if (mismatch) fail <= 1'b1;
      cmp_valid <= 1'b0;
      case (state)
        IDLE, DONE: if (start) begin
          state     <= RUN;
          busy      <= 1'b1;
          done      <= 1'b0;
          fail      <= 1'b0;
          elem      <= M0;
          phase     <= 1'b0;
          mem_cs    <= 1'b1;
          mem_rwbar <= 1'b0;
          mem_wdata <= ELEM_WR_ONE[M0] ? PAT1 : PAT0;
        end
        RUN: begin
          // The op now on the bus is compared one edge after the memory returns it.
          cmp_valid <= op_read;
          cmp_exp   <= ELEM_EXP_ONE[elem] ? PAT1 : PAT0;
          if (!addr_end) begin
            phase     <= 1'b1;
            mem_rwbar <= 1'b0;
          end else if (!last || elem != M5) begin
            phase     <= 1'b0;
            elem      <= elem_next;
            mem_rwbar <= (elem_next != M0);
            mem_wdata <= ELEM_WR_ONE[elem_next] ? PAT1 : PAT0;
          end else begin
            state     <= DRAIN;
            mem_cs    <= 1'b0;
            mem_rwbar <= 1'b1;
          end
        end
        DRAIN: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MARCH_DIAG_EN
  logic [AW-1:0] cmp_addr;
  elem_e         cmp_elem;

  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_addr  <= '0;
      cmp_elem  <= M0;
      fail_addr <= '0;
      fail_elem <= '0;
    end else begin
      if (state == RUN) begin
        cmp_addr <= mem_addr;
        cmp_elem <= elem;
      end
      if (accept) begin
        fail_addr <= '0;
        fail_elem <= '0;
      end else if (mismatch && !fail) begin
        fail_addr <= cmp_addr;
        fail_elem <= cmp_elem;
      end
    end
  end
`else
  assign fail_addr = '0;
  assign fail_elem = '0;
`endif

endmodule

// File: tb/tb_bist_march_ctrl.sv
// Directed bench for bist_march_ctrl: 64x8 memory model plus an op-sequence scoreboard.
module tb_bist_march_ctrl;

  typedef struct packed {
    logic       rd;
    logic [5:0] addr;
    logic [7:0] data;
  } op_t;

  logic       clk = 1'b0;
  logic       rst, start;
  logic       busy, done, fail, mem_cs, mem_rwbar;
  logic [5:0] mem_addr, fail_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = 8'h00;
  logic [2:0] fail_elem;
  logic       stuck = 1'b0;

  logic [7:0] mem [64];
  op_t        q [$];
  logic [7:0] rpat [6];
  logic [7:0] wpat [6];
  logic       op_rw [640];
  logic [5:0] op_addr [640];
  logic [7:0] op_rd [640];
  int         op_idx, cs_count, prev_idx, busy_cycles;
  logic       prev_rd = 1'b0;
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  bist_march_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .fail      (fail),
    .mem_cs    (mem_cs),
    .mem_rwbar (mem_rwbar),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .fail_addr (fail_addr),
    .fail_elem (fail_elem)
  );

  // Synchronous memory, one-edge read latency; optional bit0 stuck-at-1 at 0x15.
  always @(posedge clk) begin
    if (mem_cs) begin
      if (!mem_rwbar) mem[mem_addr] <= mem_wdata;
      else mem_rdata <= mem[mem_addr] | ((stuck && mem_addr == 6'h15) ? 8'h01 : 8'h00);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Bus monitor: pops the scoreboard on every issued op and records the op history.
  always @(negedge clk) begin
    op_t e;
    if (prev_rd && prev_idx < 640) op_rd[prev_idx] = mem_rdata;
    prev_rd = 1'b0;
    if (mem_cs === 1'b1) begin
      cs_count++;
      if (q.size() == 0) begin
        check("op_unexpected", 1, 0);
      end else begin
        e = q.pop_front();
        check("op_rw", mem_rwbar, e.rd);
        check("op_addr", mem_addr, e.addr);
        if (!e.rd) check("op_wdata", mem_wdata, e.data);
      end
      if (op_idx < 640) begin
        op_rw[op_idx]   = mem_rwbar;
        op_addr[op_idx] = mem_addr;
        prev_rd  = mem_rwbar;
        prev_idx = op_idx;
      end
      op_idx++;
    end
  end

  task automatic push_run();
    logic [5:0] a;
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < 64; i++) begin
        a = (e == 3 || e == 4) ? 6'(63 - i) : 6'(i);
        if (e == 0) begin
          q.push_back('{1'b0, a, wpat[0]});
        end else begin
          q.push_back('{1'b1, a, rpat[e]});
          if (e != 5) q.push_back('{1'b0, a, wpat[e]});
        end
      end
    end
  endtask

  // Drives a one-cycle start (sampled at E0); returns just after E0.
  task automatic launch();
    q.delete();
    push_run();
    cs_count = 0;
    op_idx   = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts busy samples after E0..En; optionally re-asserts start at sample restart_at.
  task automatic wait_done(input int restart_at);
    busy_cycles = 0;
    for (int k = 0; k < 2000 && busy === 1'b1; k++) begin
      busy_cycles++;
      start = (k == restart_at);
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic check_pass_run(input string tag);
    check({tag, "_busy_cycles"}, busy_cycles, 641);
    check({tag, "_done"}, done, 1);
    check({tag, "_fail"}, fail, 0);
    check({tag, "_cs_count"}, cs_count, 640);
    check({tag, "_sb_empty"}, q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rpat = '{8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00};
    wpat = '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00};
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fail", fail, 0);
    check("rst_cs", mem_cs, 0);
    check("rst_rwbar", mem_rwbar, 1);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_fail_addr", fail_addr, 0);
    check("rst_fail_elem", fail_elem, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Fault-free run with address/data sequence spot checks.
    launch();
    check("run1_busy_e0", busy, 1);
    check("run1_cs_e0", mem_cs, 1);
    wait_done(-1);
    check_pass_run("run1");
    check("run1_idle_cs", mem_cs, 0);
    check("run1_idle_rwbar", mem_rwbar, 1);
    check("m3_first_rw", op_rw[320], 1);
    check("m3_first_addr", op_addr[320], 6'h3F);
    check("m3_first_rdata", op_rd[320], 8'h00);
    check("m5_last_rw", op_rw[639], 1);
    check("m5_last_addr", op_addr[639], 6'h3F);
    check("m5_last_rdata", op_rd[639], 8'h00);

    // Stuck-at-1 on bit0 of address 0x15: first caught by M1 r0.
    stuck = 1'b1;
    launch();
    wait_done(-1);
    check("flt_busy_cycles", busy_cycles, 641);
    check("flt_done", done, 1);
    check("flt_fail", fail, 1);
    check("flt_cs_count", cs_count, 640);
`ifdef MARCH_DIAG_EN
    check("flt_fail_addr", fail_addr, 6'h15);
    check("flt_fail_elem", fail_elem, 1);
`else
    check("flt_fail_addr", fail_addr, 0);
    check("flt_fail_elem", fail_elem, 0);
`endif

    // Second start after a failing run clears fail on acceptance.
    stuck = 1'b0;
    launch();
    check("rerun_fail_cleared", fail, 0);
    check("rerun_done_cleared", done, 0);
    check("rerun_fail_addr_cleared", fail_addr, 0);
    check("rerun_fail_elem_cleared", fail_elem, 0);
    wait_done(-1);
    check_pass_run("rerun");

    // Start re-asserted at op 50 is ignored.
    launch();
    wait_done(50);
    check_pass_run("restart");

    // Reset mid-run at op 100, then a clean run.
    launch();
    repeat (100) @(posedge clk);
    #1;
    check("midrst_op100_cs", mem_cs, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_cs", mem_cs, 0);
    check("midrst_busy", busy, 0);
    check("midrst_fail", fail, 0);
    check("midrst_done", done, 0);
    check("midrst_addr", mem_addr, 0);
    check("midrst_rwbar", mem_rwbar, 1);
    rst = 1'b0;
    q.delete();
    @(posedge clk); #1;
    launch();
    wait_done(-1);
    check_pass_run("postrst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
